// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side responder for the CPU memory bus.
// Holds a word-addressed RAM at word addresses 0..DEPTH-1 and a four-word
// countdown timer at TIMER_BASE..TIMER_BASE+3 that raises hwint on expiry.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset (timer only; RAM is not cleared)
//   addr     word address (CPU b_bus)
//   wr_data  write data (CPU a_bus)
//   rd_data  read data onto the shared result_bus; hi-Z unless mem_rd && !mem_wr
//   mem_rd   read strobe (combinational, zero-latency read)
//   mem_wr   write strobe (takes effect on the rising clk edge)
//   hwint    interrupt request: PEND & IRQ_EN
//
// Timer map (word offsets): 0 CTRL {AUTO,IRQ_EN,EN}, 1 LOAD, 2 COUNT,
// 3 STATUS {PEND} (write 1 to clear).
module mem_bus_responder #(
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] TIMER_BASE = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output tri   [31:0] rd_data,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic        hwint
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  logic        ram_hit;
  logic        timer_hit;
  logic [31:0] toff;
  logic [1:0]  reg_sel;

  logic        en;
  logic        irq_en;
  logic        auto_rl;
  logic [31:0] load;
  logic [31:0] count;
  logic        pend;

  logic        tmr_wr;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_count;
  logic        wr_status;
  logic        cnt_wr;
  logic        expire;
  logic [31:0] rd_val;

  // Full 32-bit decode so aliases of the low address bits never hit.
  assign ram_hit   = addr < 32'(DEPTH);
  assign toff      = addr - TIMER_BASE;
  assign timer_hit = (addr >= TIMER_BASE) && (toff < 32'd4);
  assign reg_sel   = toff[1:0];

  assign tmr_wr    = mem_wr && timer_hit;
  assign wr_ctrl   = tmr_wr && (reg_sel == 2'd0);
  assign wr_load   = tmr_wr && (reg_sel == 2'd1);
  assign wr_count  = tmr_wr && (reg_sel == 2'd2);
  assign wr_status = tmr_wr && (reg_sel == 2'd3);

  // A bus write to LOAD/COUNT pre-empts both decrement and expiry.
  assign cnt_wr = wr_load || wr_count;
  assign expire = en && !cnt_wr && (count == '0);

  // RAM writes are independent of rst.
  always_ff @(posedge clk) begin
    if (mem_wr && ram_hit) begin
      mem[addr[AW-1:0]] <= wr_data;
    end
  end

  // Later assignments deliberately override the countdown: CTRL write beats
  // the expiry's EN clear, LOAD/COUNT writes beat the countdown, and an
  // expiry beats a STATUS clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      auto_rl <= 1'b0;
      load    <= '0;
      count   <= '0;
      pend    <= 1'b0;
    end else begin
      if (en && !cnt_wr) begin
        if (count != '0) begin
          count <= count - 32'd1;
        end else if (auto_rl) begin
          count <= load;
        end else begin
          en <= 1'b0;
        end
      end

      if (expire) begin
        pend <= 1'b1;
      end else if (wr_status && wr_data[0]) begin
        pend <= 1'b0;
      end

      if (wr_ctrl) begin
        en      <= wr_data[0];
        irq_en  <= wr_data[1];
        auto_rl <= wr_data[2];
      end

      if (wr_load) begin
        load  <= wr_data;
        count <= wr_data;
      end

      if (wr_count) begin
        count <= wr_data;
      end
    end
  end

  assign hwint = pend & irq_en;

  always_comb begin
    rd_val = '0;
    if (ram_hit) begin
      rd_val = mem[addr[AW-1:0]];
    end else if (timer_hit) begin
      case (reg_sel)
        2'd0:    rd_val = {29'd0, auto_rl, irq_en, en};
        2'd1:    rd_val = load;
        2'd2:    rd_val = count;
        default: rd_val = {31'd0, pend};
      endcase
    end
  end

  // A simultaneous read+write is illegal from the CPU; stay off the bus.
  assign rd_data = (mem_rd && !mem_wr) ? rd_val : 'z;

endmodule
